// File: rtl/axis_pkt_router.sv
// axis_pkt_router: single-input, NUM_PORTS-output AXI-Stream packet router.
// The destination field in each packet's header beat selects the output port.
// Packets with an out-of-range destination are discarded. Saturating counters
// track forwarded and dropped packets.
module axis_pkt_router #(
  parameter int TDATA_WIDTH = 32,
  parameter int NUM_PORTS   = 4,
  parameter int DEST_WIDTH  = 3,
  parameter int DEST_LSB    = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tlast,
  output logic [NUM_PORTS-1:0]   m_axis_tvalid,
  input  logic [NUM_PORTS-1:0]   m_axis_tready,
  output logic [15:0]            pkt_count,
  output logic [15:0]            drop_count
);

  localparam int SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t                 state_q;
  logic                   valid_q;
  logic [TDATA_WIDTH-1:0] data_q;
  logic                   last_q;
  logic [SEL_W-1:0]       sel_q;
  logic [SEL_W-1:0]       route_q;
  logic [15:0]            pkt_q;
  logic [15:0]            drop_q;
  logic [15:0]            pkt_d;
  logic [15:0]            drop_d;

  logic                   sel_ready;
  logic                   drain;
  logic                   accept;
  logic [DEST_WIDTH-1:0]  dest;
  logic                   dest_ok;

  // Handshake decode, header destination decode and saturating counter next values
  always_comb begin
    sel_ready     = m_axis_tready[sel_q];
    drain         = valid_q & sel_ready;
    s_axis_tready = (state_q == DROP) ? 1'b1 : (~valid_q | sel_ready);
    accept        = s_axis_tvalid & s_axis_tready;
    dest          = s_axis_tdata[DEST_LSB +: DEST_WIDTH];
    dest_ok       = ({{(32-DEST_WIDTH){1'b0}}, dest} < 32'(NUM_PORTS));
    pkt_d         = (pkt_q  == 16'hFFFF) ? pkt_q  : pkt_q  + 16'd1;
    drop_d        = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
  end

  // Packet FSM, single-entry output register and packet counters.
  // A load in the same cycle as a drain overrides the clear, keeping valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      sel_q   <= '0;
      route_q <= '0;
      pkt_q   <= '0;
      drop_q  <= '0;
    end else begin
      if (drain) valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (dest_ok) begin
              valid_q <= 1'b1;
              data_q  <= s_axis_tdata;
              last_q  <= s_axis_tlast;
              sel_q   <= SEL_W'(dest);
              route_q <= SEL_W'(dest);
              if (s_axis_tlast) pkt_q <= pkt_d;
              else              state_q <= FWD;
            end else begin
              drop_q <= drop_d;
              if (!s_axis_tlast) state_q <= DROP;
            end
          end
        end
        FWD: begin
          if (accept) begin
            valid_q <= 1'b1;
            data_q  <= s_axis_tdata;
            last_q  <= s_axis_tlast;
            sel_q   <= route_q;
            if (s_axis_tlast) begin
              pkt_q   <= pkt_d;
              state_q <= IDLE;
            end
          end
        end
        DROP: begin
          if (accept && s_axis_tlast) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output port mapping from the output register
  always_comb begin
    m_axis_tvalid = valid_q ? (NUM_PORTS'(1) << sel_q) : '0;
    m_axis_tdata  = data_q;
    m_axis_tlast  = last_q;
    pkt_count     = pkt_q;
    drop_count    = drop_q;
  end

endmodule
